// File: rtl/fan_tach_bank.sv
// fan_tach_bank: N-channel fan tachometer with gate-window RPM, stall/low flags and a level IRQ.
// Define TACH_MINMAX_EN to build per-channel min/max RPM tracking.

module fan_tach_chan #(
    parameter int RPM_MUL        = 120,
    parameter int PULSES_PER_REV = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int STALL_WINDOWS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tach,
    input  logic        win_end,
    input  logic        en,
    input  logic        thr_we,
    input  logic [15:0] wdata,
    input  logic [1:0]  w1c,
`ifdef TACH_MINMAX_EN
    input  logic        min_clr,
    input  logic        max_clr,
    output logic [15:0] min_v,
    output logic [15:0] max_v,
`endif
    output logic [15:0] rpm,
    output logic [15:0] thr,
    output logic [2:0]  status
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int SW = $clog2(STALL_WINDOWS + 1);

    logic [2:0]    sync;
    logic [FW-1:0] fcnt;
    logic          filt, filt_d, rise;
    logic [15:0]   edges;
    logic [SW-1:0] stall_cnt;
    logic [31:0]   rpm_full;
    logic [15:0]   rpm_new;
    logic          upd, stall_set, low_set;

    // Any sample differing from the accepted level advances the counter; a match restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            fcnt   <= '0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
        end else begin
            sync   <= {sync[1:0], tach};
            filt_d <= filt;
            if (sync[2] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
                filt <= sync[2];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign rise = filt & ~filt_d;

    // An edge on the window-end cycle is the first edge of the new window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            edges <= '0;
        else if (win_end)
            edges <= {15'd0, rise};
        else if (rise && edges != 16'hFFFF)
            edges <= edges + 1'b1;
    end

    assign rpm_full  = (32'(edges) * 32'(RPM_MUL)) / 32'(PULSES_PER_REV);
    assign rpm_new   = (rpm_full > 32'h0000_FFFF) ? 16'hFFFF : rpm_full[15:0];
    assign upd       = win_end & en;
    assign stall_set = upd && (edges == 16'd0) && (stall_cnt >= SW'(STALL_WINDOWS - 1));
    assign low_set   = upd && (rpm_new < thr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpm       <= '0;
            thr       <= '0;
            status    <= '0;
            stall_cnt <= '0;
        end else begin
            if (thr_we)
                thr <= wdata;
            status[0] <= stall_set | (status[0] & ~w1c[0]);
            status[1] <= low_set | (status[1] & ~w1c[1]);
            if (upd) begin
                rpm       <= rpm_new;
                status[2] <= 1'b1;
                if (edges != 16'd0)
                    stall_cnt <= '0;
                else if (stall_cnt != SW'(STALL_WINDOWS))
                    stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

`ifdef TACH_MINMAX_EN
    logic [15:0] min_base, max_base;

    // A clear landing on a window end is applied before the new sample is folded in.
    assign min_base = min_clr ? 16'hFFFF : min_v;
    assign max_base = max_clr ? 16'h0000 : max_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_v <= 16'hFFFF;
            max_v <= 16'h0000;
        end else if (upd) begin
            min_v <= (rpm_new < min_base) ? rpm_new : min_base;
            max_v <= (rpm_new > max_base) ? rpm_new : max_base;
        end else begin
            min_v <= min_base;
            max_v <= max_base;
        end
    end
`endif
endmodule

module fan_tach_bank #(
    parameter int NUM_CHANNELS   = 4,
    parameter int REFCLK_HZ      = 250000000,
    parameter int WINDOW_DIV     = 2,
    parameter int PULSES_PER_REV = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int STALL_WINDOWS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] tach,
    input  logic                    rd_en,
    input  logic [7:0]              rd_addr,
    output logic                    rd_valid,
    output logic [15:0]             rd_data,
    input  logic                    wr_en,
    input  logic [7:0]              wr_addr,
    input  logic [15:0]             wr_data,
    output logic                    irq
);
    localparam int WIN = REFCLK_HZ / WINDOW_DIV;
    localparam int TW  = (WIN > 1) ? $clog2(WIN) : 1;

    logic [TW-1:0]                 win_cnt;
    logic                          win_end;
    logic [NUM_CHANNELS-1:0]       en_mask, irq_mask, irq_stat;
    logic [NUM_CHANNELS-1:0][15:0] rpm_a, thr_a;
    logic [NUM_CHANNELS-1:0][2:0]  stat_a;
`ifdef TACH_MINMAX_EN
    logic [NUM_CHANNELS-1:0][15:0] min_a, max_a;
`endif
    logic [15:0]                   rd_mux;

    assign win_end = (win_cnt == TW'(WIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win_cnt <= '0;
        else
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic sel;
        assign sel         = wr_en && (wr_addr[7:3] == 5'(i));
        assign irq_stat[i] = (stat_a[i][0] | stat_a[i][1]) & irq_mask[i];

        fan_tach_chan #(
            .RPM_MUL        (60 * WINDOW_DIV),
            .PULSES_PER_REV (PULSES_PER_REV),
            .FILTER_CYCLES  (FILTER_CYCLES),
            .STALL_WINDOWS  (STALL_WINDOWS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tach    (tach[i]),
            .win_end (win_end),
            .en      (en_mask[i]),
            .thr_we  (sel && wr_addr[2:0] == 3'd3),
            .wdata   (wr_data),
            .w1c     ((sel && wr_addr[2:0] == 3'd4) ? wr_data[1:0] : 2'b00),
`ifdef TACH_MINMAX_EN
            .min_clr (sel && wr_addr[2:0] == 3'd1),
            .max_clr (sel && wr_addr[2:0] == 3'd2),
            .min_v   (min_a[i]),
            .max_v   (max_a[i]),
`endif
            .rpm     (rpm_a[i]),
            .thr     (thr_a[i]),
            .status  (stat_a[i])
        );
    end

    // Reads see register state before any write in the same cycle.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            8'hF0:   rd_mux = 16'(en_mask);
            8'hF1:   rd_mux = 16'(irq_mask);
            8'hF2:   rd_mux = 16'(irq_stat);
            8'hF3:   rd_mux = 16'(NUM_CHANNELS);
            default: ;
        endcase
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_addr[7:3] == 5'(c)) begin
                case (rd_addr[2:0])
                    3'd0:    rd_mux = rpm_a[c];
`ifdef TACH_MINMAX_EN
                    3'd1:    rd_mux = min_a[c];
                    3'd2:    rd_mux = max_a[c];
`endif
                    3'd3:    rd_mux = thr_a[c];
                    3'd4:    rd_mux = {13'd0, stat_a[c]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_mask  <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en && wr_addr == 8'hF0)
                en_mask <= wr_data[NUM_CHANNELS-1:0];
            if (wr_en && wr_addr == 8'hF1)
                irq_mask <= wr_data[NUM_CHANNELS-1:0];
            irq      <= |irq_stat;
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_fan_tach_bank.sv
// Scoreboard bench for fan_tach_bank: 500-cycle windows, per-channel tach patterns, register reads checked in order.
module tb_fan_tach_bank;
`ifdef TACH_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    localparam logic [15:0] MIN_RST = MM ? 16'hFFFF : 16'h0000;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } rd_exp_t;

    logic        clk, rst;
    logic [3:0]  tach;
    logic        rd_en, rd_valid, wr_en, irq;
    logic [7:0]  rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic        sat_rd_valid, sat_irq;
    logic [15:0] sat_rd_data;

    rd_exp_t sb[$];
    int      k;
    int      n_chk = 0;
    int      n_fail = 0;

    fan_tach_bank #(.NUM_CHANNELS(4), .REFCLK_HZ(1000), .WINDOW_DIV(2)) dut (
        .clk(clk), .rst(rst), .tach(tach), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .irq(irq)
    );

    // Same 500-cycle window, but 3000 rpm per edge so 25 edges overflow 16 bits.
    fan_tach_bank #(.NUM_CHANNELS(4), .REFCLK_HZ(25000), .WINDOW_DIV(50), .PULSES_PER_REV(1)) sat_dut (
        .clk(clk), .rst(rst), .tach(tach), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(sat_rd_valid), .rd_data(sat_rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .irq(sat_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tach_at(input int kk);
        int w, p, n3;
        logic [3:0] t;
        w  = kk / 500;
        p  = kk % 500;
        n3 = (w % 2 == 0) ? 10 : 30;
        t  = '0;
        t[0] = (p >= 10) && (p < 460) && (((p - 10) % 18) < 9);
        t[1] = t[0] || (p >= 1 && p <= 3) || (p >= 465 && p <= 467) || (p >= 480 && p <= 482);
        t[3] = (p >= 5) && (p < 5 + 16 * n3) && (((p - 5) % 16) < 8);
        return t;
    endfunction

    // k counts clock edges since reset release, matching the DUT window timer phase.
    initial begin
        k    = 0;
        tach = '0;
        forever begin
            @(posedge clk);
            if (rst) k = 0;
            else     k = k + 1;
            #1 tach = tach_at(k);
        end
    end

    initial begin
        bit      pend;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            pend = rd_en;
            @(negedge clk);
            if (pend || rd_valid) begin
                chk("rd_valid", 16'(rd_valid), 16'(pend));
                if (pend) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 16'd1, 16'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("rd@%02h", e.addr), rd_data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_to(input int n);
        while (k < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [15:0] d);
        sb.push_back('{a, d});
        rd_addr = a;
        rd_en   = 1'b1;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
    endtask

    task automatic do_rw(input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
        sb.push_back('{a, exp_rd});
        rd_addr = a;
        wr_addr = a;
        wr_data = d;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("rst_rd_data", rd_data, 16'd0);
        chk("rst_irq", 16'(irq), 16'd0);
        rst = 1'b0;

        wait_to(2);
        do_read(8'hF3, 16'd4);
        do_read(8'h00, 16'd0);
        do_read(8'h19, MIN_RST);
        do_read(8'h1A, 16'd0);
        do_read(8'h1B, 16'd0);
        do_read(8'h04, 16'd0);
        do_read(8'hF0, 16'd0);
        do_write(8'hF0, 16'h000F);
        do_rw(8'hF1, 16'h0004, 16'h0000);
        do_read(8'hF1, 16'h0004);
        do_write(8'h1B, 16'd1000);
        do_read(8'h1B, 16'd1000);
        do_write(8'h23, 16'h0055);
        do_read(8'h23, 16'd0);
        do_read(8'h1D, 16'd0);

        // First window end at edge 500.
        wait_to(510);
        do_read(8'h00, 16'h05DC);
        @(negedge clk);
        chk("sat_rpm", sat_rd_data, 16'hFFFF);
        @(negedge clk);
        chk("rd_hold", rd_data, 16'h05DC);
        do_read(8'h04, 16'h0004);
        do_read(8'h08, 16'd1500);
        do_read(8'h0C, 16'h0004);
        do_read(8'h14, 16'h0004);
        do_read(8'h18, 16'd600);
        do_read(8'h1C, 16'h0006);
        do_read(8'hF2, 16'h0000);
        chk("irq_w1", 16'(irq), 16'd0);

        wait_to(1010);
        do_read(8'h18, 16'd1800);
        do_read(8'h19, MM ? 16'd600 : 16'd0);
        do_read(8'h1A, MM ? 16'd1800 : 16'd0);

        wait_to(1100);
        do_write(8'h19, 16'h0000);
        do_read(8'h19, MIN_RST);

        // Stall declared on the third empty window (edge 1500), irq one cycle later.
        wait_to(1490);
        chk("irq_pre_stall", 16'(irq), 16'd0);
        wait_to(1500);
        @(negedge clk);
        chk("irq_stall_lat", 16'(irq), 16'd0);
        @(negedge clk);
        chk("irq_stall", 16'(irq), 16'd1);
        do_read(8'h14, 16'h0005);
        do_read(8'hF2, 16'h0004);
        do_read(8'h19, MM ? 16'd600 : 16'd0);

        wait_to(1600);
        do_write(8'h14, 16'h0001);
        wait_to(1605);
        chk("irq_cleared", 16'(irq), 16'd0);
        do_read(8'h14, 16'h0004);

        // W1C lands on the window end that re-sets stall.
        wait_to(1999);
        do_write(8'h14, 16'h0001);
        wait_to(2005);
        do_read(8'h14, 16'h0005);
        chk("irq_set_wins", 16'(irq), 16'd1);

        // Max clear lands on a window end with rpm=600.
        wait_to(2499);
        do_write(8'h1A, 16'h0000);
        wait_to(2510);
        do_read(8'h1A, MM ? 16'd600 : 16'd0);
        do_read(8'h19, MM ? 16'd600 : 16'd0);

        wait_to(2600);
        do_write(8'hF0, 16'h0007);
        wait_to(3010);
        do_read(8'h18, 16'd600);
        do_read(8'h08, 16'd1500);

        wait_to(3200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("mid_rst_rd_data", rd_data, 16'd0);
        chk("mid_rst_irq", 16'(irq), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        wait_to(2);
        do_read(8'hF0, 16'd0);
        do_read(8'h00, 16'd0);
        do_read(8'h1B, 16'd0);
        do_read(8'h14, 16'd0);
        chk("post_rst_irq", 16'(irq), 16'd0);
        do_write(8'hF0, 16'h000F);
        wait_to(510);
        do_read(8'h00, 16'd1500);
        do_read(8'h14, 16'h0004);
        do_read(8'h18, 16'd600);
        do_read(8'h1C, 16'h0004);

        repeat (3) @(negedge clk);
        chk("sb_drain", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
